spi_reg_bridge: RTL

SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

---
 rtl/spi_reg_bridge_pkg.sv | 25 ++
 rtl/spi_reg_bridge_sync_edge.sv | 26 ++
 rtl/spi_reg_bridge.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_bridge_pkg.sv
// SPI register bridge: shared frame layout,
// counter widths and FSM state encoding.
package spi_reg_bridge_pkg;

  localparam int FRAME_BITS    = 32;
  localparam int CMD_WRITE_BIT = 7;
  localparam int CNT_W         = 6;
  localparam int ADR_W         = 8;
  localparam int DAT_W         = 16;

  // Bit counter value seen while the last bit
  // of each field is being taken.
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(15);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(FRAME_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_OVERRUN
  } state_e;

endpackage

// File: rtl/spi_reg_bridge_sync_edge.sv
// Two-flop synchronizer with edge detection
// on the synchronized value.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sh_q;

  // shift in the async input; bit 2 keeps the previous synced value
  always_ff @(posedge clock) begin
    if (!reset) sh_q <= {3{RST_VAL}};
    else        sh_q <= {sh_q[1:0], async_i};
  end

  assign sync_o = sh_q[1];
  assign rise_o = sh_q[1] & ~sh_q[2];
  assign fall_o = ~sh_q[1] & sh_q[2];

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that turns 32-bit frames
// into register-file reads and writes.
module spi_reg_bridge
  import spi_reg_bridge_pkg::*;
#(
  parameter int CLK_RATIO_MIN = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic [ADR_W-1:0] adr_out,
  output logic [DAT_W-1:0] data_wr,
  output logic             wr_enable,
  input  logic [DAT_W-1:0] data_rd,
  output logic [7:0]       frame_cnt,
  output logic             frame_err,
  input  logic             frame_err_rst
);

  logic sclk_sync, sclk_rise, sclk_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  sync_edge #(.RST_VAL(1'b0)) u_sclk (
    .clock(clock), .reset(reset), .async_i(sclk),
    .sync_o(sclk_sync), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  sync_edge #(.RST_VAL(1'b1)) u_cs (
    .clock(clock), .reset(reset), .async_i(cs_n),
    .sync_o(cs_sync), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  sync_edge #(.RST_VAL(1'b0)) u_mosi (
    .clock(clock), .reset(reset), .async_i(mosi),
    .sync_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
  );

  logic unused_sig;
  assign unused_sig = ^{sclk_sync, cs_rise, mosi_rise,
                        mosi_fall, CLK_RATIO_MIN[0]};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [14:0]      sr_q;
  logic             wr_q;
  logic [1:0]       settle_q;
  logic             armed_q;
  logic [1:0]       ld_q;
  logic [DAT_W-1:0] mshift_q;
  logic             miso_q;
  logic             wr_pend_q;
  logic             wr_en_q;
  logic [ADR_W-1:0] adr_q;
  logic [DAT_W-1:0] dwr_q;
  logic [7:0]       fcnt_q;
  logic             ferr_q;

  logic start, take_bit, cmd_done, addr_done;
  logic frame_done, abort, overrun;
  logic [7:0] rx_byte;

  assign rx_byte = {sr_q[6:0], mosi_s};

  // state register
  always_ff @(posedge clock) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // next state: cs_n high always returns to idle
  always_comb begin
    state_d = state_q;
    if (state_q != ST_IDLE && cs_sync) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:
          if (start) state_d = ST_CMD;
        ST_CMD:
          if (cmd_done) state_d = ST_ADDR;
        ST_ADDR:
          if (addr_done) state_d = ST_DATA;
        ST_DATA:
          if (frame_done) state_d = ST_OVERRUN;
        ST_OVERRUN:
          state_d = ST_OVERRUN;
        default:
          state_d = ST_IDLE;
      endcase
    end
  end

  // per-state strobes driving the datapath
  always_comb begin
    start      = 1'b0;
    take_bit   = 1'b0;
    cmd_done   = 1'b0;
    addr_done  = 1'b0;
    frame_done = 1'b0;
    abort      = 1'b0;
    overrun    = 1'b0;
    unique case (state_q)
      ST_IDLE:
        start = cs_fall & armed_q;
      ST_CMD, ST_ADDR, ST_DATA: begin
        take_bit   = sclk_rise & ~cs_sync;
        abort      = cs_sync & (cnt_q != '0);
        cmd_done   = take_bit & (state_q == ST_CMD)
                   & (cnt_q == CMD_LAST);
        addr_done  = take_bit & (state_q == ST_ADDR)
                   & (cnt_q == ADDR_LAST);
        frame_done = take_bit & (state_q == ST_DATA)
                   & (cnt_q == DATA_LAST);
      end
      ST_OVERRUN:
        overrun = sclk_rise & ~cs_sync;
      default: ;
    endcase
  end

  // arm only once cs_n is seen high after reset, so a
  // frame cut by reset is ignored until the next fall
  always_ff @(posedge clock) begin
    if (!reset) begin
      settle_q <= 2'd0;
      armed_q  <= 1'b0;
    end else begin
      if (settle_q != 2'd2) settle_q <= settle_q + 2'd1;
      if (settle_q == 2'd2 && cs_sync) armed_q <= 1'b1;
    end
  end

  // receive shift, command/address capture, bit count
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
      sr_q  <= '0;
      wr_q  <= 1'b0;
      adr_q <= '0;
    end else begin
      if (start)         cnt_q <= '0;
      else if (take_bit) cnt_q <= cnt_q + 1'b1;
      if (take_bit)  sr_q  <= {sr_q[13:0], mosi_s};
      if (start)     wr_q  <= 1'b0;
      if (cmd_done)  wr_q  <= rx_byte[CMD_WRITE_BIT];
      if (addr_done) adr_q <= rx_byte;
    end
  end

  // read path: load readback two clocks after the
  // address update, shift out on sclk falling edges
  always_ff @(posedge clock) begin
    if (!reset) begin
      ld_q     <= '0;
      mshift_q <= '0;
      miso_q   <= 1'b0;
    end else begin
      ld_q <= {ld_q[0], addr_done & ~wr_q};
      if (start) begin
        mshift_q <= '0;
        miso_q   <= 1'b0;
      end else if (ld_q[1]) begin
        mshift_q <= data_rd;
      end else if (sclk_fall && state_q == ST_DATA && !wr_q) begin
        miso_q   <= mshift_q[15];
        mshift_q <= {mshift_q[14:0], 1'b0};
      end
    end
  end

  // write strobe, frame counter and sticky error
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_pend_q <= 1'b0;
      wr_en_q   <= 1'b0;
      dwr_q     <= '0;
      fcnt_q    <= '0;
      ferr_q    <= 1'b0;
    end else begin
      wr_pend_q <= frame_done & wr_q;
      wr_en_q   <= wr_pend_q;
      if (frame_done && wr_q) dwr_q <= {sr_q, mosi_s};
      if (frame_done) fcnt_q <= fcnt_q + 8'd1;
      if (abort || overrun)   ferr_q <= 1'b1;
      else if (frame_err_rst) ferr_q <= 1'b0;
    end
  end

  assign miso      = miso_q & (state_q == ST_DATA) & ~wr_q;
  assign adr_out   = adr_q;
  assign data_wr   = dwr_q;
  assign wr_enable = wr_en_q;
  assign frame_cnt = fcnt_q;
  assign frame_err = ferr_q;

endmodule
